alu_hs: RTL

- Parametrised successor to the team's 3-bit-opcode ALU, with configurable operand width.
- Registered result and 4-bit status flags.
- valid/ready handshakes on input and output.
- Multi-cycle shift-add multiply, driven by a small FSM.
- Sits between the operand/opcode source and the result consumer in the datapath; one operation in flight at a time.

---
 rtl/alu_hs.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_hs.sv
// Handshaked ALU with registered result/status and a shift-add multiplier FSM.
// Optional macro ALU_HS_SAT_EN: ADD/SUB saturate to signed limits on overflow.
module alu_hs #(
  parameter int WIDTH = 13,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           status_q, status_d;
  logic                 out_valid_q, out_valid_d;
  logic                 init_q, init_d;

  logic [WIDTH:0]       sum_s, diff_s;
  logic [2*WIDTH-1:0]   shl_s, shr_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_c_s, alu_v_s;
  logic                 accept_s;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // init_q holds off in_ready for the first cycle after reset release.
  assign in_ready  = init_q && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;

  // Single-cycle operations; shifts go through a double-width vector so the
  // last bit shifted out lands in a fixed position and large amounts yield 0.
  always_comb begin
    sum_s     = {1'b0, x} + {1'b0, y};
    diff_s    = {1'b0, x} - {1'b0, y};
    shl_s     = {{WIDTH{1'b0}}, x} << y[SW-1:0];
    shr_s     = {x, {WIDTH{1'b0}}} >> y[SW-1:0];
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (opcode)
      3'd0: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_s[WIDTH-1] != x[WIDTH-1]);
      end
      3'd1: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (x[WIDTH-1] != y[WIDTH-1]) && (diff_s[WIDTH-1] != x[WIDTH-1]);
      end
      3'd2: alu_res_s = x & y;
      3'd3: alu_res_s = x | y;
      3'd4: alu_res_s = x ^ y;
      3'd5: begin
        alu_res_s = shl_s[WIDTH-1:0];
        alu_c_s   = shl_s[WIDTH];
      end
      3'd6: begin
        alu_res_s = shr_s[2*WIDTH-1:WIDTH];
        alu_c_s   = shr_s[WIDTH-1];
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
`ifdef ALU_HS_SAT_EN
    // On overflow the sign of x gives the direction for both ADD and SUB.
    if (alu_v_s) begin
      alu_res_s = x[WIDTH-1] ? SMIN : SMAX;
    end else begin
      alu_res_s = alu_res_s;
    end
`endif
  end

  // Next-state, multiplier datapath and output-slot control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    init_d      = 1'b1;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s && (opcode == 3'd7)) begin
          state_d  = MUL;
          cnt_d    = {SW{1'b0}};
          mcand_d  = {{WIDTH{1'b0}}, x};
          mplier_d = y;
          prod_d   = {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
          result_d    = alu_res_s;
          status_d    = {alu_c_s, alu_v_s, alu_res_s[WIDTH-1], alu_res_s == {WIDTH{1'b0}}};
          out_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end else begin
          prod_d = prod_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(SW-1){1'b0}}, 1'b1};
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        if (!out_valid_q || out_ready) begin
          result_d    = prod_q[WIDTH-1:0];
          status_d    = {|prod_q[2*WIDTH-1:WIDTH], 1'b0, prod_q[WIDTH-1],
                         prod_q[WIDTH-1:0] == {WIDTH{1'b0}}};
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= {SW{1'b0}};
      mcand_q     <= {(2*WIDTH){1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      prod_q      <= {(2*WIDTH){1'b0}};
      result_q    <= {WIDTH{1'b0}};
      status_q    <= 4'd0;
      out_valid_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      init_q      <= init_d;
    end
  end

endmodule
